// File: rtl/sdcard_block_writer_fsm.sv
// SD card SPI-mode block writer: CMD24/CMD25, 512-byte payload framing, data-response check, busy polling.
// Optional CRC16-CCITT generation on the payload when SD_WRITE_CRC16_EN is defined; otherwise CRC bytes are 0xFF.
//
// state        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | waiting for trigger with card configured
// S_CMD_REQ    | command index driven, waiting for engine to go busy
// S_CMD_WAIT   | NOCMD driven, waiting for engine to return idle
// S_R1_CHK     | check R1 for zero
// S_GAP        | one 0xFF byte before the start token
// S_TOKEN      | start token (0xFC multi, 0xFE single)
// S_DATA_REQ   | payload fetch strobe issued
// S_DATA_LATCH | payload byte captured and launched
// S_DATA_SEND  | payload byte on the wire
// S_CRC_HI     | first CRC byte
// S_CRC_LO     | second CRC byte
// S_RESP       | clock out data-response token
// S_BUSY       | poll until card releases busy
// S_STOP_TOKEN | multi-block stop token 0xFD
// S_STOP_GAP   | one 0xFF after stop token
// S_STOP_BUSY  | poll busy after stop token

module sdcard_block_writer_fsm #(
    parameter int SD_BLOCK_ADDR_BITS    = 32,
    parameter int SD_BLOCK_LENGTH_BYTES = 512,
    parameter int BUSY_TIMEOUT          = 65535,
    parameter int CMD_BITS              = 6,
    parameter int CMD_RESP_BITS         = 40,
    parameter logic [CMD_BITS-1:0] NOCMD = {CMD_BITS{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          card_configured,
    input  logic                          block_write_trigger,
    input  logic                          block_write_continous_mode,
    input  logic [SD_BLOCK_ADDR_BITS-1:0] block_write_block_addr,
    input  logic [7:0]                    block_write_data_in,
    output logic [8:0]                    block_write_data_idx,
    output logic                          block_write_data_req,
    output logic                          block_write_card_ready,
    output logic                          block_write_done,
    output logic                          block_write_error,
    output logic [2:0]                    block_write_error_code,
    input  logic                          cmd_ready,
    output logic [CMD_BITS-1:0]           cmd_req_idx,
    output logic [SD_BLOCK_ADDR_BITS-1:0] cmd_block_addr,
    input  logic [CMD_RESP_BITS-1:0]      cmd_response_bytes,
    input  logic                          spi_ready,
    output logic                          spi_req,
    output logic [7:0]                    spi_tx_data,
    input  logic [7:0]                    spi_rx_data
);

    localparam logic [CMD_BITS-1:0] CMD24     = CMD_BITS'(24);
    localparam logic [CMD_BITS-1:0] CMD25     = CMD_BITS'(25);
    localparam int                  BW        = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [BW-1:0]       BUSY_LOAD = BW'(BUSY_TIMEOUT - 1);
    localparam logic [8:0]          LAST_IDX  = 9'(SD_BLOCK_LENGTH_BYTES - 1);

    localparam logic [2:0] ERR_R1      = 3'd1;
    localparam logic [2:0] ERR_CRC     = 3'd2;
    localparam logic [2:0] ERR_WRITE   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_RESP    = 3'd5;

    typedef enum logic [4:0] {
        S_IDLE,
        S_CMD_REQ,
        S_CMD_WAIT,
        S_R1_CHK,
        S_GAP,
        S_TOKEN,
        S_DATA_REQ,
        S_DATA_LATCH,
        S_DATA_SEND,
        S_CRC_HI,
        S_CRC_LO,
        S_RESP,
        S_BUSY,
        S_STOP_TOKEN,
        S_STOP_GAP,
        S_STOP_BUSY
    } state_t;

    state_t         state;
    logic           multi_q;
    logic           xfer_wait;
    logic [BW-1:0]  busy_cnt;
    logic           byte_done;
    logic [4:0]     resp_tok;
    logic [7:0]     crc_hi_byte;
    logic [7:0]     crc_lo_byte;
    logic           unused_resp_bits;

    // A byte is finished on the first cycle the SPI master is idle again after it went busy.
    assign byte_done        = xfer_wait & spi_ready;
    assign resp_tok         = spi_rx_data[4:0];
    assign unused_resp_bits = ^cmd_response_bytes[CMD_RESP_BITS-1:8];

`ifdef SD_WRITE_CRC16_EN
    logic [15:0] crc_q;

    function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        end
        return x;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            crc_q <= 16'h0000;
        end else if (state == S_TOKEN) begin
            crc_q <= 16'h0000;
        end else if (state == S_DATA_LATCH) begin
            crc_q <= crc16_upd(crc_q, block_write_data_in);
        end
    end

    assign crc_hi_byte = crc_q[15:8];
    assign crc_lo_byte = crc_q[7:0];
`else
    assign crc_hi_byte = 8'hFF;
    assign crc_lo_byte = 8'hFF;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= S_IDLE;
            multi_q                <= 1'b0;
            xfer_wait              <= 1'b0;
            busy_cnt               <= '0;
            block_write_data_idx   <= 9'd0;
            block_write_data_req   <= 1'b0;
            block_write_card_ready <= 1'b0;
            block_write_done       <= 1'b0;
            block_write_error      <= 1'b0;
            block_write_error_code <= 3'd0;
            cmd_req_idx            <= NOCMD;
            cmd_block_addr         <= '0;
            spi_req                <= 1'b0;
            spi_tx_data            <= 8'hFF;
        end else begin
            block_write_done     <= 1'b0;
            block_write_data_req <= 1'b0;

            if (spi_req && !spi_ready) begin
                spi_req   <= 1'b0;
                xfer_wait <= 1'b1;
            end
            if (byte_done) begin
                xfer_wait <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    block_write_card_ready <= 1'b1;
                    if (block_write_trigger && card_configured) begin
                        block_write_card_ready <= 1'b0;
                        block_write_error      <= 1'b0;
                        block_write_error_code <= 3'd0;
                        multi_q                <= block_write_continous_mode;
                        cmd_block_addr         <= block_write_block_addr;
                        cmd_req_idx            <= block_write_continous_mode ? CMD25 : CMD24;
                        block_write_data_idx   <= 9'd0;
                        state                  <= S_CMD_REQ;
                    end
                end

                S_CMD_REQ: begin
                    if (!cmd_ready) begin
                        cmd_req_idx <= NOCMD;
                        state       <= S_CMD_WAIT;
                    end
                end

                S_CMD_WAIT: begin
                    if (cmd_ready) begin
                        state <= S_R1_CHK;
                    end
                end

                S_R1_CHK: begin
                    if (cmd_response_bytes[7:0] != 8'h00) begin
                        block_write_error      <= 1'b1;
                        block_write_error_code <= ERR_R1;
                        state                  <= S_IDLE;
                    end else begin
                        spi_tx_data <= 8'hFF;
                        spi_req     <= 1'b1;
                        state       <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (byte_done) begin
                        spi_tx_data <= multi_q ? 8'hFC : 8'hFE;
                        spi_req     <= 1'b1;
                        state       <= S_TOKEN;
                    end
                end

                S_TOKEN: begin
                    if (byte_done) begin
                        block_write_data_req <= 1'b1;
                        state                <= S_DATA_REQ;
                    end
                end

                S_DATA_REQ: begin
                    state <= S_DATA_LATCH;
                end

                S_DATA_LATCH: begin
                    spi_tx_data <= block_write_data_in;
                    spi_req     <= 1'b1;
                    state       <= S_DATA_SEND;
                end

                S_DATA_SEND: begin
                    if (byte_done) begin
                        if (block_write_data_idx == LAST_IDX) begin
                            block_write_data_idx <= 9'd0;
                            spi_tx_data          <= crc_hi_byte;
                            spi_req              <= 1'b1;
                            state                <= S_CRC_HI;
                        end else begin
                            block_write_data_idx <= block_write_data_idx + 9'd1;
                            block_write_data_req <= 1'b1;
                            state                <= S_DATA_REQ;
                        end
                    end
                end

                S_CRC_HI: begin
                    if (byte_done) begin
                        spi_tx_data <= crc_lo_byte;
                        spi_req     <= 1'b1;
                        state       <= S_CRC_LO;
                    end
                end

                S_CRC_LO: begin
                    if (byte_done) begin
                        spi_tx_data <= 8'hFF;
                        spi_req     <= 1'b1;
                        state       <= S_RESP;
                    end
                end

                S_RESP: begin
                    if (byte_done) begin
                        if (resp_tok == 5'h05) begin
                            busy_cnt    <= BUSY_LOAD;
                            spi_tx_data <= 8'hFF;
                            spi_req     <= 1'b1;
                            state       <= S_BUSY;
                        end else begin
                            block_write_error <= 1'b1;
                            if (resp_tok == 5'h0B) begin
                                block_write_error_code <= ERR_CRC;
                            end else if (resp_tok == 5'h0D) begin
                                block_write_error_code <= ERR_WRITE;
                            end else begin
                                block_write_error_code <= ERR_RESP;
                            end
                            // A rejected block in a multi-block run still needs the stop token.
                            if (multi_q) begin
                                spi_tx_data <= 8'hFD;
                                spi_req     <= 1'b1;
                                state       <= S_STOP_TOKEN;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                end

                S_BUSY: begin
                    if (byte_done) begin
                        if (spi_rx_data != 8'h00) begin
                            block_write_done <= 1'b1;
                            if (!multi_q) begin
                                state <= S_IDLE;
                            end else if (block_write_trigger) begin
                                spi_tx_data <= 8'hFF;
                                spi_req     <= 1'b1;
                                state       <= S_GAP;
                            end else begin
                                spi_tx_data <= 8'hFD;
                                spi_req     <= 1'b1;
                                state       <= S_STOP_TOKEN;
                            end
                        end else if (busy_cnt == '0) begin
                            block_write_error      <= 1'b1;
                            block_write_error_code <= ERR_TIMEOUT;
                            state                  <= S_IDLE;
                        end else begin
                            busy_cnt    <= busy_cnt - 1'b1;
                            spi_tx_data <= 8'hFF;
                            spi_req     <= 1'b1;
                        end
                    end
                end

                S_STOP_TOKEN: begin
                    if (byte_done) begin
                        spi_tx_data <= 8'hFF;
                        spi_req     <= 1'b1;
                        state       <= S_STOP_GAP;
                    end
                end

                S_STOP_GAP: begin
                    if (byte_done) begin
                        busy_cnt    <= BUSY_LOAD;
                        spi_tx_data <= 8'hFF;
                        spi_req     <= 1'b1;
                        state       <= S_STOP_BUSY;
                    end
                end

                S_STOP_BUSY: begin
                    if (byte_done) begin
                        if (spi_rx_data != 8'h00) begin
                            state <= S_IDLE;
                        end else if (busy_cnt == '0) begin
                            block_write_error      <= 1'b1;
                            block_write_error_code <= ERR_TIMEOUT;
                            state                  <= S_IDLE;
                        end else begin
                            busy_cnt    <= busy_cnt - 1'b1;
                            spi_tx_data <= 8'hFF;
                            spi_req     <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdcard_block_writer_fsm.sv
// Directed bench for sdcard_block_writer_fsm with behavioural SPI master, card, command engine and data buffer.
module tb_sdcard_block_writer_fsm;

    localparam logic [5:0] NOCMD = 6'h3F;
    localparam int C_IDLE = 0, C_DATA = 1, C_RESP = 2, C_BUSY = 3, C_STOPGAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_configured = 1'b1;
    logic        block_write_trigger = 1'b0;
    logic        block_write_continous_mode = 1'b0;
    logic [31:0] block_write_block_addr = 32'h0;
    logic [7:0]  block_write_data_in = 8'h00;
    logic [8:0]  block_write_data_idx;
    logic        block_write_data_req;
    logic        block_write_card_ready;
    logic        block_write_done;
    logic        block_write_error;
    logic [2:0]  block_write_error_code;
    logic        cmd_ready;
    logic [5:0]  cmd_req_idx;
    logic [31:0] cmd_block_addr;
    logic [39:0] cmd_response_bytes;
    logic        spi_ready;
    logic        spi_req;
    logic [7:0]  spi_tx_data;
    logic [7:0]  spi_rx_data;

    logic [7:0]  r1_val = 8'h00;
    logic [7:0]  resp_tok = 8'hE5;
    int          busy_n = 2;
    int          data_mode = 0;
    int          clr_req = 0;
    int          done_cnt = 0;
    logic [5:0]  last_cmd = NOCMD;
    logic [31:0] last_addr = 32'h0;
    int          cmd_cnt = 0;
    logic [7:0]  log_q[$];

    int n_checks = 0;
    int n_pass = 0;

    assign cmd_response_bytes = {32'h0, r1_val};

    sdcard_block_writer_fsm #(
        .SD_BLOCK_ADDR_BITS(32),
        .SD_BLOCK_LENGTH_BYTES(512),
        .BUSY_TIMEOUT(16),
        .CMD_BITS(6),
        .CMD_RESP_BITS(40),
        .NOCMD(NOCMD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .card_configured(card_configured),
        .block_write_trigger(block_write_trigger),
        .block_write_continous_mode(block_write_continous_mode),
        .block_write_block_addr(block_write_block_addr),
        .block_write_data_in(block_write_data_in),
        .block_write_data_idx(block_write_data_idx),
        .block_write_data_req(block_write_data_req),
        .block_write_card_ready(block_write_card_ready),
        .block_write_done(block_write_done),
        .block_write_error(block_write_error),
        .block_write_error_code(block_write_error_code),
        .cmd_ready(cmd_ready),
        .cmd_req_idx(cmd_req_idx),
        .cmd_block_addr(cmd_block_addr),
        .cmd_response_bytes(cmd_response_bytes),
        .spi_ready(spi_ready),
        .spi_req(spi_req),
        .spi_tx_data(spi_tx_data),
        .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // SPI master plus card: card behaviour follows the byte stream it receives.
    initial begin : spi_card
        int cst;
        int dcnt;
        int bcnt;
        int clr_seen;
        logic [7:0] tx;
        logic [7:0] rx;
        cst = C_IDLE; dcnt = 0; bcnt = 0; clr_seen = 0;
        spi_ready = 1'b1;
        spi_rx_data = 8'hFF;
        forever begin
            @(posedge clk); #1;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                cst = C_IDLE;
            end
            if (spi_req && spi_ready) begin
                tx = spi_tx_data;
                log_q.push_back(tx);
                rx = 8'hFF;
                case (cst)
                    C_IDLE: begin
                        if (tx == 8'hFE || tx == 8'hFC) begin cst = C_DATA; dcnt = 0; end
                        else if (tx == 8'hFD) cst = C_STOPGAP;
                    end
                    C_DATA: begin
                        dcnt++;
                        if (dcnt == 514) cst = C_RESP;
                    end
                    C_RESP: begin
                        rx = resp_tok;
                        if (resp_tok[4:0] == 5'h05) begin cst = C_BUSY; bcnt = 0; end
                        else cst = C_IDLE;
                    end
                    C_BUSY: begin
                        if (bcnt < busy_n) begin rx = 8'h00; bcnt++; end
                        else cst = C_IDLE;
                    end
                    C_STOPGAP: begin
                        cst = C_BUSY; bcnt = 0;
                    end
                    default: cst = C_IDLE;
                endcase
                spi_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                spi_rx_data = rx;
                spi_ready = 1'b1;
            end
        end
    end

    initial begin : cmd_engine
        cmd_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (cmd_req_idx != NOCMD && cmd_ready) begin
                last_cmd = cmd_req_idx;
                last_addr = cmd_block_addr;
                cmd_cnt++;
                cmd_ready = 1'b0;
                while (cmd_req_idx != NOCMD) begin
                    @(posedge clk); #1;
                end
                repeat (2) @(posedge clk);
                #1 cmd_ready = 1'b1;
            end
        end
    end

    initial begin : data_buffer
        forever begin
            @(posedge clk); #1;
            if (block_write_data_req) begin
                case (data_mode)
                    1: block_write_data_in = 8'h00;
                    2: block_write_data_in = 8'hFF;
                    default: block_write_data_in = block_write_data_idx[7:0];
                endcase
            end
        end
    end

    always @(negedge clk) if (block_write_done) done_cnt++;

    task automatic clear_card();
        clr_req++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_write(input logic multi, input logic [31:0] addr, input logic hold);
        @(posedge clk); #1;
        block_write_continous_mode = multi;
        block_write_block_addr = addr;
        block_write_trigger = 1'b1;
        @(posedge clk); #1;
        if (!hold) block_write_trigger = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!block_write_card_ready && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready"}, block_write_card_ready, 1'b1);
    endtask

    initial begin : main
        int lb;
        int d0;
        int c0;
        int bad;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_spi_req", spi_req, 1'b0);
        check("rst_cmd_idx", cmd_req_idx, NOCMD);
        check("rst_spi_tx", spi_tx_data, 8'hFF);
        check("rst_done", block_write_done, 1'b0);
        check("rst_error", block_write_error, 1'b0);
        check("rst_ready", block_write_card_ready, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_ready", block_write_card_ready, 1'b1);

        // Trigger while the card is not configured is ignored.
        card_configured = 1'b0;
        c0 = cmd_cnt;
        start_write(1'b0, 32'h5, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("unconf_cmd_cnt", cmd_cnt, c0);
        check("unconf_ready", block_write_card_ready, 1'b1);
        card_configured = 1'b1;

        // Single-block write.
        clear_card();
        lb = log_q.size(); d0 = done_cnt;
        start_write(1'b0, 32'h10, 1'b0);
        wait_ready("single");
        check("single_cmd", last_cmd, 6'd24);
        check("single_addr", last_addr, 32'h10);
        check("single_len", log_q.size() - lb, 520);
        check("single_gap", log_q[lb], 8'hFF);
        check("single_token", log_q[lb+1], 8'hFE);
        bad = 0;
        for (int k = 0; k < 512; k++) if (log_q[lb+2+k] !== 8'(k)) bad++;
        check("single_data_err", bad, 0);
`ifndef SD_WRITE_CRC16_EN
        check("single_crc0", log_q[lb+514], 8'hFF);
        check("single_crc1", log_q[lb+515], 8'hFF);
`endif
        check("single_done", done_cnt - d0, 1);
        check("single_error", block_write_error, 1'b0);

        // Two-block multi write: trigger held through the first post-busy sample.
        clear_card();
        lb = log_q.size(); d0 = done_cnt;
        start_write(1'b1, 32'h200, 1'b1);
        n = 0;
        while (!block_write_done && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("multi_first_done", block_write_done, 1'b1);
        block_write_trigger = 1'b0;
        wait_ready("multi");
        check("multi_cmd", last_cmd, 6'd25);
        check("multi_len", log_q.size() - lb, 1045);
        check("multi_token0", log_q[lb+1], 8'hFC);
        check("multi_gap1", log_q[lb+520], 8'hFF);
        check("multi_token1", log_q[lb+521], 8'hFC);
        check("multi_stop", log_q[lb+1040], 8'hFD);
        check("multi_stop_gap", log_q[lb+1041], 8'hFF);
        check("multi_done", done_cnt - d0, 2);
        check("multi_error", block_write_error, 1'b0);

        // CRC reject in single mode.
        clear_card();
        resp_tok = 8'h0B;
        d0 = done_cnt;
        start_write(1'b0, 32'h11, 1'b0);
        wait_ready("crcrej");
        check("crcrej_error", block_write_error, 1'b1);
        check("crcrej_code", block_write_error_code, 3'd2);
        check("crcrej_done", done_cnt - d0, 0);

        // Next accepted trigger clears the sticky error.
        clear_card();
        resp_tok = 8'hE5;
        start_write(1'b0, 32'h12, 1'b0);
        check("clear_error", block_write_error, 1'b0);
        check("clear_code", block_write_error_code, 3'd0);
        wait_ready("clear");
        check("clear_error_end", block_write_error, 1'b0);

        // Write reject in multi mode still sends the stop sequence.
        clear_card();
        resp_tok = 8'h0D;
        lb = log_q.size(); d0 = done_cnt;
        start_write(1'b1, 32'h13, 1'b0);
        wait_ready("wrrej");
        check("wrrej_code", block_write_error_code, 3'd3);
        check("wrrej_stop", log_q[lb+517], 8'hFD);
        check("wrrej_len", log_q.size() - lb, 522);
        check("wrrej_done", done_cnt - d0, 0);

        // Unrecognised data response.
        clear_card();
        resp_tok = 8'h07;
        start_write(1'b0, 32'h14, 1'b0);
        wait_ready("badresp");
        check("badresp_code", block_write_error_code, 3'd5);
        resp_tok = 8'hE5;

        // Nonzero R1 aborts before any data byte.
        clear_card();
        r1_val = 8'h04;
        lb = log_q.size();
        start_write(1'b0, 32'h15, 1'b0);
        wait_ready("r1");
        check("r1_code", block_write_error_code, 3'd1);
        check("r1_len", log_q.size() - lb, 0);
        r1_val = 8'h00;

        // Busy timeout: card never releases busy; 16 polls allowed.
        clear_card();
        busy_n = 1000;
        lb = log_q.size(); d0 = done_cnt;
        start_write(1'b0, 32'h16, 1'b0);
        wait_ready("tmo");
        check("tmo_code", block_write_error_code, 3'd4);
        check("tmo_len", log_q.size() - lb, 517 + 16);
        check("tmo_done", done_cnt - d0, 0);
        busy_n = 2;

        // Reset in the middle of the payload.
        clear_card();
        start_write(1'b0, 32'h20, 1'b0);
        n = 0;
        while (block_write_data_idx != 9'd200 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_idx", block_write_data_idx, 9'd200);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_spi_req", spi_req, 1'b0);
        check("rst_mid_cmd", cmd_req_idx, NOCMD);
        check("rst_mid_data_req", block_write_data_req, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", block_write_card_ready, 1'b1);
        repeat (10) @(posedge clk);

`ifdef SD_WRITE_CRC16_EN
        clear_card();
        data_mode = 1;
        lb = log_q.size();
        start_write(1'b0, 32'h30, 1'b0);
        wait_ready("crc_zero");
        check("crc_zero_hi", log_q[lb+514], 8'h00);
        check("crc_zero_lo", log_q[lb+515], 8'h00);
        clear_card();
        data_mode = 2;
        lb = log_q.size();
        start_write(1'b0, 32'h31, 1'b0);
        wait_ready("crc_ff");
        check("crc_ff_hi", log_q[lb+514], 8'h7F);
        check("crc_ff_lo", log_q[lb+515], 8'hA1);
        data_mode = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
